// File: rtl/mmio_console.sv
// mmio_console: MMIO console/exit peripheral on the core store path.
// Console bytes go through a FIFO into an 8N1 UART transmitter. An exit write
// becomes visible on exit_valid only once every earlier byte has left tx.
module mmio_console #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] CONSOLE_ADDR = 32'hFFFF0000,
  parameter logic [31:0] EXIT_ADDR    = 32'hABCD0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        st_valid_i,
  input  logic [31:0] st_addr_i,
  input  logic [31:0] st_data_i,
  output logic        st_ready_o,
  output logic        st_hit_o,
  output logic        tx_o,
  output logic        busy_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_code_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            exit_pending_q, exit_valid_q;
  logic [31:0]     exit_code_q;

  logic is_con, is_exit, exit_lock, full, nonempty, baud_last;
  logic push, pop, exit_wr;

  assign is_con    = (st_addr_i == CONSOLE_ADDR);
  assign is_exit   = (st_addr_i == EXIT_ADDR);
  // Once an exit is seen every later store is swallowed, so nothing may stall.
  assign exit_lock = exit_pending_q | exit_valid_q;
  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign nonempty  = (count_q != '0);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  assign st_hit_o   = is_con | is_exit;
  assign st_ready_o = !(is_con && full && !exit_lock);

  // Full FIFO refuses a push even when a pop lands on the same edge.
  assign push    = st_valid_i && is_con && !exit_lock && !full;
  // Pops only from a non-empty FIFO: no bypass of an empty buffer.
  assign pop     = nonempty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));
  assign exit_wr = st_valid_i && is_exit && !exit_lock;

  assign tx_o         = tx_q;
  assign busy_o       = nonempty || (state_q != S_IDLE) || exit_pending_q;
  assign exit_valid_o = exit_valid_q;
  assign exit_code_o  = exit_code_q;

  // FIFO pointer/count next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents need no reset, the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= st_data_i[7:0];
  end

  // FIFO pointer/count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // 8N1 transmitter, LSB first; STOP chains straight into the next START.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          baud_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rptr_q];
            state_q <= S_START;
            tx_q    <= 1'b0;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q  <= '0;
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rptr_q];
              state_q <= S_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Exit latch: hold the code, report only after the transmitter drains.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_pending_q <= 1'b0;
      exit_valid_q   <= 1'b0;
      exit_code_q    <= '0;
    end else if (exit_wr) begin
      exit_code_q    <= st_data_i;
      exit_pending_q <= 1'b1;
    end else if (exit_pending_q && !nonempty && (state_q == S_IDLE)) begin
      exit_valid_q   <= 1'b1;
      exit_pending_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: directed stimulus with a scoreboard. Stores push expected
// UART bytes / exit codes into queues; a UART receiver and an exit watcher
// pop and compare whenever the DUT produces a frame or raises exit_valid.
module tb_mmio_console;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] CON   = 32'hFFFF0000;
  localparam logic [31:0] EXA   = 32'hABCD0000;

  logic        clk = 1'b0, rst = 1'b1, st_valid = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0;
  logic        st_ready, st_hit, tx, busy, exit_valid;
  logic [31:0] exit_code;

  mmio_console #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
                 .CONSOLE_ADDR(CON), .EXIT_ADDR(EXA)) dut (
    .clk_i(clk), .rst_i(rst), .st_valid_i(st_valid), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_ready_o(st_ready), .st_hit_o(st_hit),
    .tx_o(tx), .busy_o(busy), .exit_valid_o(exit_valid), .exit_code_o(exit_code));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exit_q[$];
  int          frame_start[$];
  int          exit_rise_cyc = -1;
  bit          in_frame = 1'b0;
  bit          lock_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // UART receiver: samples mid-bit, aborts the frame on reset.
  logic [7:0] mon_b;
  bit         mon_ab;
  int         mon_s;
  initial forever begin
    @(negedge clk);
    if (!rst && tx === 1'b0) begin
      mon_b = '0; mon_ab = 1'b0; mon_s = cyc; in_frame = 1'b1;
      for (int c = 1; c < 10 * CPB; c++) begin
        @(negedge clk);
        if (rst) begin mon_ab = 1'b1; break; end
        if (c % CPB == CPB / 2) begin
          if (c / CPB == 0)      chk("start_bit", {31'b0, tx}, 32'd0);
          else if (c / CPB <= 8) mon_b[c / CPB - 1] = tx;
          else                   chk("stop_bit", {31'b0, tx}, 32'd1);
        end
      end
      in_frame = 1'b0;
      if (!mon_ab) begin
        frame_start.push_back(mon_s);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL uart_unexpected: got byte %0h, expected no frame", mon_b);
        end else chk("uart_byte", {24'b0, mon_b}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  // Exit watcher: compare exit_code on each rising exit_valid.
  logic ev_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (exit_valid && !ev_prev) begin
      exit_rise_cyc = cyc;
      if (exit_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL exit_unexpected: got code %0h, expected no exit", exit_code);
      end else chk("exit_code", exit_code, exit_q.pop_front());
    end
    ev_prev = exit_valid;
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int acc, output int waited);
    int w;
    w = 0;
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d;
    #1;
    while (!st_ready && w < 200) begin @(negedge clk); #1; w++; end
    if (!st_ready) begin
      n_chk++; n_fail++;
      $display("FAIL store_timeout: got st_ready 0, expected 1 within 200 cycles");
      st_valid = 1'b0; acc = -1; waited = w;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    if (!lock_m) begin
      if (a == CON) exp_q.push_back(d[7:0]);
      else if (a == EXA) begin exit_q.push_back(d); lock_m = 1'b1; end
    end
    st_valid = 1'b0;
    waited = w;
  endtask

  task automatic wait_drain(input string nm);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || in_frame) && w < 5000) begin @(negedge clk); w++; end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; exp_q.delete(); exit_q.delete(); lock_m = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int acc[18];
  int wt, a0, a1, a2;
  bit low_seen, busy_seen;
  bit exp_bits[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_exit_valid", {31'b0, exit_valid}, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_st_ready", {31'b0, st_ready}, 1);
    rst = 1'b0;

    // Address decode
    st_addr = CON;           #1 chk("hit_console", {31'b0, st_hit}, 1);
    st_addr = EXA;           #1 chk("hit_exit", {31'b0, st_hit}, 1);
    st_addr = 32'h00000100;  #1 chk("hit_miss_100", {31'b0, st_hit}, 0);
    chk("ready_miss_100", {31'b0, st_ready}, 1);
    st_addr = 32'hFFFF0001;  #1 chk("hit_miss_ffff0001", {31'b0, st_hit}, 0);

    // Misses: no tx activity, not busy
    store(32'h00000100, 32'h41, a0, wt);
    store(32'hFFFF0001, 32'h42, a0, wt);
    low_seen = 0; busy_seen = 0;
    repeat (20) begin @(negedge clk); if (!tx) low_seen = 1; if (busy) busy_seen = 1; end
    chk("miss_tx_quiet", {31'b0, low_seen}, 0);
    chk("miss_not_busy", {31'b0, busy_seen}, 0);

    // Single character 0x41, exact bit timing
    store(CON, 32'h41, a0, wt);
    @(negedge clk);
    chk("single_tx_before_start", {31'b0, tx}, 1);
    chk("single_busy_queued", {31'b0, busy}, 1);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      if (i % CPB == 0 || i % CPB == CPB - 1)
        chk($sformatf("single_bit%0d", i / CPB), {31'b0, tx}, {31'b0, exp_bits[i / CPB]});
    end
    chk("single_busy_last_stop", {31'b0, busy}, 1);
    @(negedge clk);
    chk("single_busy_done", {31'b0, busy}, 0);
    chk("single_tx_idle", {31'b0, tx}, 1);
    wait_drain("single_drain");

    // Backpressure: 18 back-to-back writes into a 16-deep FIFO
    frame_start.delete();
    for (int i = 0; i < 18; i++) store(CON, 32'h10 + i, acc[i], wt);
    chk("bp_byte16_accept", acc[16] - acc[0], 16);
    chk("bp_byte17_accept", acc[17] - acc[0], 42);
    chk("bp_byte17_stall", wt, 25);
    wait_drain("bp_drain");
    chk("bp_frames", frame_start.size(), 18);
    if (frame_start.size() == 18) begin
      chk("bp_first_start", frame_start[0] - acc[0], 1);
      for (int i = 1; i < 18; i++)
        chk($sformatf("bp_gap%0d", i), frame_start[i] - frame_start[i - 1], 10 * CPB);
    end

    // Exit flush: exit waits for both frames
    exit_rise_cyc = -1;
    store(CON, 32'h48, a0, wt);
    store(CON, 32'h69, a1, wt);
    store(EXA, 32'd3, a2, wt);
    chk("flush_exit_low_early", {31'b0, exit_valid}, 0);
    begin
      int w; w = 0;
      while (!exit_valid && w < 500) begin @(negedge clk); w++; end
    end
    chk("flush_exit_rise", exit_rise_cyc - a0, 20 * CPB + 2);
    chk("flush_drained", exp_q.size(), 0);
    store(CON, 32'h5A, a0, wt);
    chk("post_exit_console_ready", wt, 0);
    store(EXA, 32'd7, a0, wt);
    chk("post_exit_exit_ready", wt, 0);
    low_seen = 0;
    repeat (60) begin @(negedge clk); if (!tx) low_seen = 1; end
    chk("post_exit_tx_quiet", {31'b0, low_seen}, 0);
    chk("post_exit_code", exit_code, 3);
    chk("post_exit_valid", {31'b0, exit_valid}, 1);

    // Immediate exit from an idle block
    do_reset();
    @(negedge clk);
    chk("reset_clears_exit", {31'b0, exit_valid}, 0);
    store(EXA, 32'hFFFFFFFF, a0, wt);
    chk("imm_exit_not_yet", {31'b0, exit_valid}, 0);
    chk("imm_busy_pending", {31'b0, busy}, 1);
    @(posedge clk); #1;
    chk("imm_exit_valid", {31'b0, exit_valid}, 1);
    chk("imm_exit_code", exit_code, 32'hFFFFFFFF);
    chk("imm_busy_clear", {31'b0, busy}, 0);

    // Reset mid-frame during data bit 3 with two bytes queued
    do_reset();
    store(CON, 32'hA5, a0, wt);
    store(CON, 32'h3C, a1, wt);
    store(CON, 32'h7E, a2, wt);
    begin
      int w; w = 0;
      while (cyc < a0 + 18 && w < 100) begin @(negedge clk); w++; end
    end
    chk("midframe_bit3", {31'b0, tx}, 0);
    rst = 1'b1; exp_q.delete(); lock_m = 1'b0;
    @(posedge clk); #1;
    chk("midframe_rst_tx", {31'b0, tx}, 1);
    chk("midframe_rst_busy", {31'b0, busy}, 0);
    chk("midframe_rst_exit", {31'b0, exit_valid}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame_start.delete();
    store(CON, 32'h55, a0, wt);
    wait_drain("midframe_drain");
    repeat (2 * 10 * CPB) @(negedge clk);
    chk("midframe_one_frame", frame_start.size(), 1);
    chk("midframe_idle_busy", {31'b0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
